// File: rtl/hc595_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hc595_pkg
// Description : Frame geometry and sr-to-frame mapping for the hc595 receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package hc595_pkg;

    localparam int FRAME_BITS = 14;
    localparam int SEL_W      = 6;
    localparam int LIGHT_W    = 8;
    localparam int BITCNT_W   = 4;

    localparam logic [BITCNT_W-1:0] FRAME_CNT = BITCNT_W'(FRAME_BITS);

    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic [LIGHT_W-1:0] light;
    } frame_t;

    // First bit on the wire is sel[0], so it ends up in the MSB of sr.
    function automatic frame_t sr_to_frame(input logic [FRAME_BITS-1:0] sr);
        frame_t f;
        f.light = sr[LIGHT_W-1:0];
        f.sel   = '0;
        for (int k = 0; k < SEL_W; k++) begin
            f.sel[k] = sr[FRAME_BITS-1-k];
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hc595_rx_if
// Description : 595-style serial display link (ds/shcp/stcp, roe with
//               HC595_RX_OE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
interface hc595_rx_if;

    logic ds;
    logic shcp;
    logic stcp;
`ifdef HC595_RX_OE_EN
    logic roe;

    modport master (output ds, shcp, stcp, roe);
    modport slave  (input  ds, shcp, stcp, roe);
`else
    modport master (output ds, shcp, stcp);
    modport slave  (input  ds, shcp, stcp);
`endif

endinterface
`default_nettype wire

// File: rtl/hc595_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hc595_sync
// Description : N-stage synchronizer with a delayed copy and a registered
//               rising-edge pulse aligned to that copy.
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic i_d,
    output logic      o_dly,
    output logic      o_rise
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q,  prev_d;
    logic              rise_q,  rise_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], i_d};
        prev_d  = chain_q[STAGES-1];
        rise_d  = chain_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    // o_dly and o_rise describe the same sample, keeping ds aligned to shcp.
    assign o_dly  = prev_q;
    assign o_rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/hc595_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hc595_rx
// Description : 74HC595-style link receiver: oversampled shift/storage pair
//               producing sel/light frames. Optional roe via HC595_RX_OE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    hc595_rx_if.slave         link,
    output logic [SEL_W-1:0]  sel_out,
    output logic [LIGHT_W-1:0] light_out,
    output logic              qh_out,
    output logic              frame_valid,
    output logic              frame_err
);

    logic ds_dly;
    logic ds_rise_unused;
    logic shcp_dly_unused;
    logic shcp_rise;
    logic stcp_dly_unused;
    logic stcp_rise;

    hc595_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (link.ds),
        .o_dly  (ds_dly),
        .o_rise (ds_rise_unused)
    );

    hc595_sync #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (link.shcp),
        .o_dly  (shcp_dly_unused),
        .o_rise (shcp_rise)
    );

    hc595_sync #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (link.stcp),
        .o_dly  (stcp_dly_unused),
        .o_rise (stcp_rise)
    );

    logic [FRAME_BITS-1:0] sr_q,      sr_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SEL_W-1:0]      sel_q,     sel_d;
    logic [LIGHT_W-1:0]    light_q,   light_d;
    logic                  valid_q,   valid_d;
    logic                  err_q,     err_d;
    frame_t                frame;

    always_comb begin
        frame     = sr_to_frame(sr_q);
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        sel_d     = sel_q;
        light_d   = light_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        // Latch reads sr_q, so a coincident shift never leaks into the frame.
        if (stcp_rise) begin
            sel_d     = frame.sel;
            light_d   = frame.light;
            valid_d   = 1'b1;
            err_d     = (bit_cnt_q != FRAME_CNT);
            bit_cnt_d = '0;
        end

        if (shcp_rise) begin
            sr_d = {sr_q[FRAME_BITS-2:0], ds_dly};
            if (stcp_rise) begin
                bit_cnt_d = BITCNT_W'(1);
            end else if (bit_cnt_q != '1) begin
                bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sel_q     <= '0;
            light_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            sel_q     <= sel_d;
            light_q   <= light_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign qh_out      = sr_q[FRAME_BITS-1];
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

`ifdef HC595_RX_OE_EN
    logic [1:0] roe_q, roe_d;

    always_comb begin
        roe_d = {roe_q[0], link.roe};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            roe_q <= '0;
        end else begin
            roe_q <= roe_d;
        end
    end

    // Blanking only masks the view; the storage register keeps the frame.
    assign sel_out   = roe_q[1] ? '0 : sel_q;
    assign light_out = roe_q[1] ? '0 : light_q;
`else
    assign sel_out   = sel_q;
    assign light_out = light_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hc595_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hc595_rx
// Description : Directed scoreboard bench for hc595_rx (HC595_RX_OE_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_rx;

    localparam int SS = 2;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] sel_out;
    logic [7:0] light_out;
    logic       qh_out;
    logic       frame_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    hc595_rx_if link();

    hc595_rx #(.SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .link        (link.slave),
        .sel_out     (sel_out),
        .light_out   (light_out),
        .qh_out      (qh_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    typedef struct {
        logic [5:0] sel;
        logic [7:0] light;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [13:0] m_sr   = '0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        link.ds = b;
        cyc(2);
        link.shcp = 1'b1;
        cyc(3);
        link.shcp = 1'b0;
        cyc(3);
        m_sr = {m_sr[12:0], b};
        if (m_cnt < 15) m_cnt++;
    endtask

    task automatic send_frame(input logic [5:0] sel, input logic [7:0] light);
        for (int k = 0; k < 6; k++) send_bit(sel[k]);
        for (int k = 7; k >= 0; k--) send_bit(light[k]);
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        for (int k = 0; k < 6; k++) e.sel[k] = m_sr[13-k];
        e.light = m_sr[7:0];
        e.err   = (m_cnt != 14);
        return e;
    endfunction

    // Waits for the frame_valid pulse, pops the scoreboard and compares.
    task automatic wait_frame(input string tag);
        int   n;
        logic seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (frame_valid === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(n), 32'(SS + 2));
            chk({tag, "_sel"},     32'(sel_out),   32'(e.sel));
            chk({tag, "_light"},   32'(light_out), 32'(e.light));
            chk({tag, "_err"},     32'(frame_err), 32'(e.err));
            @(negedge clk);
            chk({tag, "_valid_pulse"}, 32'(frame_valid), 32'd0);
            chk({tag, "_err_pulse"},   32'(frame_err),   32'd0);
        end
    endtask

    task automatic latch(input string tag, input exp_t e);
        sb.push_back(e);
        m_cnt = 0;
        link.stcp = 1'b1;
        wait_frame(tag);
        link.stcp = 1'b0;
        cyc(3);
    endtask

    initial begin
        exp_t e;
        link.ds   = 1'b0;
        link.shcp = 1'b0;
        link.stcp = 1'b0;
`ifdef HC595_RX_OE_EN
        link.roe  = 1'b0;
`endif
        cyc(3);
        chk("reset_sel",   32'(sel_out),     32'd0);
        chk("reset_light", 32'(light_out),   32'd0);
        chk("reset_qh",    32'(qh_out),      32'd0);
        chk("reset_valid", 32'(frame_valid), 32'd0);
        chk("reset_err",   32'(frame_err),   32'd0);
        rstn = 1'b1;
        cyc(2);

        // Good frame, constant expectations.
        send_frame(6'h01, 8'hA5);
        latch("good1", '{6'h01, 8'hA5, 1'b0});

        // Short frame: outputs follow sr, error flagged.
        for (int k = 0; k < 10; k++) send_bit(1'(k % 3 == 0));
        e = model_exp();
        chk("short_model_err", 32'(e.err), 32'd1);
        latch("short", e);
        send_frame(6'h12, 8'h81);
        latch("after_short", '{6'h12, 8'h81, 1'b0});

        // Coincident shcp/stcp: latch sees pre-shift data.
        send_frame(6'h15, 8'hC3);
        link.ds = 1'b1;
        cyc(2);
        sb.push_back('{6'h15, 8'hC3, 1'b0});
        link.shcp = 1'b1;
        link.stcp = 1'b1;
        wait_frame("simul");
        m_sr  = {m_sr[12:0], 1'b1};
        m_cnt = 1;
        link.shcp = 1'b0;
        link.stcp = 1'b0;
        cyc(3);
        begin
            logic [5:0] s;
            logic [7:0] l;
            s = 6'h0B;
            l = 8'h3C;
            for (int k = 1; k < 6; k++) send_bit(s[k]);
            for (int k = 7; k >= 0; k--) send_bit(l[k]);
        end
        latch("simul_next", '{6'h0B, 8'h3C, 1'b0});

        // Reset mid-frame.
        for (int k = 0; k < 7; k++) send_bit(1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_sel",   32'(sel_out),   32'd0);
        chk("midrst_light", 32'(light_out), 32'd0);
        chk("midrst_qh",    32'(qh_out),    32'd0);
        m_sr  = '0;
        m_cnt = 0;
        cyc(2);
        rstn = 1'b1;
        cyc(2);
        send_frame(6'h3F, 8'h00);
        latch("post_reset", '{6'h3F, 8'h00, 1'b0});

        // Long frame with QH tracking.
        for (int k = 0; k < 20; k++) begin
            send_bit(1'($urandom_range(0, 1)));
            chk("qh_track", 32'(qh_out), 32'(m_sr[13]));
        end
        e = model_exp();
        chk("long_model_err", 32'(e.err), 32'd1);
        latch("long", e);

`ifdef HC595_RX_OE_EN
        send_frame(6'h2A, 8'h5A);
        latch("oe_frame", '{6'h2A, 8'h5A, 1'b0});
        link.roe = 1'b1;
        cyc(4);
        chk("oe_off_sel",   32'(sel_out),   32'd0);
        chk("oe_off_light", 32'(light_out), 32'd0);
        chk("oe_off_qh",    32'(qh_out),    32'(m_sr[13]));
        link.roe = 1'b0;
        cyc(4);
        chk("oe_on_sel",    32'(sel_out),   32'h2A);
        chk("oe_on_light",  32'(light_out), 32'h5A);
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hc595_rx.md
Name: hc595_rx

Overview:
- Receive-side deserializer for the 74HC595-style serial display link (ds/shcp/stcp/roe).
- Oversamples the three link lines on the local clock and rebuilds the 14-bit frame: 6-bit digit select plus 8-bit segment pattern.
- Presents the frame as parallel registered outputs, mirroring a 595 shift/storage register pair.
- Used as a display-side front end and as a bench-side checker for the transmit driver.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each incoming line (ds, shcp, stcp); legal range 2..4.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ds  in  1  serial data, async to clk
- shcp  in  1  shift clock; data is taken on its rising edge
- stcp  in  1  storage clock; frame latches on its rising edge
- roe  in  1  active-low output enable; present only with HC595_RX_OE_EN
- sel_out  out  6  latched digit select
- light_out  out  8  latched segment pattern
- qh_out  out  1  cascade output (shift register MSB), like the 595 QH'
- frame_valid  out  1  one-cycle pulse when a frame has been latched
- frame_err  out  1  one-cycle pulse, coincident with frame_valid, when bit count != 14

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-low (rstn).
- Reset values: sync chains, sr[13:0], bit_cnt, sel_out, light_out, qh_out, frame_valid and frame_err all 0.
- Input conditioning:
  - ds, shcp and stcp each pass through SYNC_STAGES flops.
  - One further flop per clock line gives a previous-value copy.
  - Rising edge = synced value 1 while the previous value is 0.
  - ds uses the same stage count, so its alignment relative to shcp is preserved.
- Input timing requirement: each level of shcp and stcp must persist for at least 1 clk cycle. Shorter pulses may be missed; no detection of this is required.
- Shift (cycle in which an shcp rising edge is detected):
  - sr <= {sr[12:0], ds_sync}.
  - bit_cnt <= bit_cnt + 1, saturating at 15 (4-bit).
- Bit order on the wire:
  - First bit received = sel[0], then sel[1..5].
  - Then light[7] down to light[0].
- Latch (cycle in which an stcp rising edge is detected), all registered, visible on the next clk edge:
  - sel_out[k] <= sr[13-k] for k = 0..5.
  - light_out <= sr[7:0].
  - frame_valid <= 1.
  - frame_err <= (bit_cnt != 14).
  - bit_cnt <= 0.
- Latency: SYNC_STAGES+2 clk cycles from the stcp input rise to updated outputs and the frame_valid pulse.
- Simultaneous shcp and stcp rise (same detect cycle):
  - Latch uses the pre-shift sr contents (595 semantics).
  - Shift proceeds; bit_cnt <= 1.
  - frame_err is evaluated on the old bit_cnt.
- Short or long frames:
  - The latch still occurs and the outputs update; frame_err pulses.
  - More than 15 shifts saturates bit_cnt, so the error is still flagged.
- stcp with no shifts since the last latch: outputs reload the current sr, frame_err = 1.
- qh_out = sr[13], registered.
- Reset mid-frame: everything clears immediately. The first stcp after reset with fewer than 14 shifts flags frame_err.
- frame_valid and frame_err are never high outside a latch cycle.

Optional Feature:
- HC595_RX_OE_EN defined:
  - roe port exists and is passed through a 2-flop synchronizer.
  - While synced roe = 1, sel_out and light_out read 0 (high-Z emulation).
  - The storage register keeps its value; outputs restore the held frame when roe returns to 0.
  - qh_out, frame_valid and frame_err are unaffected.
- Undefined: no roe port; outputs always show the storage register.

Decomposition:
- Package hc595_pkg:
  - FRAME_BITS = 14, SEL_W = 6, LIGHT_W = 8, BITCNT_W = 4.
  - Function mapping sr to {sel, light}.
- Sub-module hc595_sync: parameterised N-stage synchronizer with registered rising-edge pulse output.
  - Used for shcp and stcp; ds uses it with the edge output unused.

Test Plan:
- 14 bits encoding sel = 6'h01, light = 8'hA5, then stcp → sel_out = 6'h01, light_out = 8'hA5, frame_valid 1 cycle, frame_err = 0, latency = SYNC_STAGES+2.
- 10-bit frame then stcp → outputs update from sr, frame_err = 1 together with frame_valid; a following correct 14-bit frame gives frame_err = 0.
- stcp and shcp rising in the same cycle after 14 good bits → latched frame = pre-shift data, next frame starts with bit_cnt = 1.
- rstn low after 7 bits, then release, then 14 bits of sel = 6'h3F, light = 8'h00 → outputs 0 during reset, then 6'h3F/8'h00, no error.
- 20 shifts then stcp → frame_err = 1; qh_out equals the bit shifted in 13 shifts earlier throughout.
- HC595_RX_OE_EN: latch 6'h2A/8'h5A, drive roe = 1 → outputs 0 after sync delay; roe = 0 → 6'h2A/8'h5A restored without a new frame.
